// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
// mem_burst_master : single-command burst read/write initiator for the
//                    512x12 Simplez main memory (valid/ready data streams)
// Revision 1.0 - initial release
// ============================================================================
module mem_burst_master #(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] wdata,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din
);

  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_CAP   = 3'd2,
    S_RD_OUT   = 3'd3,
    S_WR_WAIT  = 3'd4,
    S_WR_PULSE = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] burst_base, burst_base_nx;
  logic [AW-1:0] burst_len, burst_len_nx;
  logic [AW-1:0] idx, idx_nx;
  logic          busy_nx, done_nx, wready_nx, rvalid_nx, wr_nx;
  logic [DW-1:0] rdata_nx, dout_nx;
  logic [AW-1:0] addr_nx;
  logic          last_word;

  assign last_word = (idx == burst_len);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      burst_base  <= '0;
      burst_len   <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wdata_ready <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_dout    <= '0;
    end else begin
      state       <= state_nx;
      burst_base  <= burst_base_nx;
      burst_len   <= burst_len_nx;
      idx         <= idx_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      wdata_ready <= wready_nx;
      rdata       <= rdata_nx;
      rdata_valid <= rvalid_nx;
      mem_addr    <= addr_nx;
      mem_wr      <= wr_nx;
      mem_dout    <= dout_nx;
    end
  end

  // Every output is registered, so each branch sets the value the output
  // must carry during the state being entered.
  always_comb begin
    state_nx      = state;
    burst_base_nx = burst_base;
    burst_len_nx  = burst_len;
    idx_nx        = idx;
    busy_nx       = busy;
    done_nx       = 1'b0;
    wready_nx     = wdata_ready;
    rdata_nx      = rdata;
    rvalid_nx     = rdata_valid;
    addr_nx       = mem_addr;
    wr_nx         = 1'b0;
    dout_nx       = mem_dout;

    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          burst_base_nx = base;
          burst_len_nx  = len;
          idx_nx        = '0;
          busy_nx       = 1'b1;
          if (op) begin
            state_nx  = S_WR_WAIT;
            wready_nx = 1'b1;
          end else begin
            state_nx = S_RD_ISSUE;
            addr_nx  = base;
          end
        end
      end
      S_RD_ISSUE: state_nx = S_RD_CAP;
      S_RD_CAP: begin
        rdata_nx  = mem_din;
        rvalid_nx = 1'b1;
        state_nx  = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (rdata_ready) begin
          rvalid_nx = 1'b0;
          if (last_word) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            idx_nx   = idx + IDX_ONE;
            addr_nx  = burst_base + idx + IDX_ONE;
            state_nx = S_RD_ISSUE;
          end
        end
      end
      S_WR_WAIT: begin
        if (wdata_valid && wdata_ready) begin
          addr_nx   = burst_base + idx;
          dout_nx   = wdata;
          wr_nx     = 1'b1;
          wready_nx = 1'b0;
          state_nx  = S_WR_PULSE;
        end
      end
      S_WR_PULSE: begin
        if (last_word) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end else begin
          idx_nx    = idx + IDX_ONE;
          wready_nx = 1'b1;
          state_nx  = S_WR_WAIT;
        end
      end
      S_DONE: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
// tb_mem_burst_master : randomized bench with a shadow-memory reference model
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_burst_master;

  localparam int AW = 9;
  localparam int DW = 12;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done;
  logic [DW-1:0] wdata = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          rdata_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din;

  always #5 clk = ~clk;

  mem_burst_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .base(base), .len(len),
    .busy(busy), .done(done),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int k);
    return DW'(k * 37 + 5);
  endfunction

  // Memory model (negedge sampling) plus protocol monitors
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  logic [DW-1:0] mem [DEPTH];
  wr_t           wr_log [$];
  int            busy_total = 0;
  int            done_total = 0;
  int            viol = 0;
  bit            mon_en = 1'b0;
  bit            cur_op = 1'b0;

  initial begin
    bit prev_wr, prev_done;
    prev_wr = 1'b0;
    prev_done = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = init_val(k);
    mem_din = '0;
    forever begin
      @(negedge clk);
      if (mem_wr) begin
        mem[mem_addr] = mem_dout;
        wr_log.push_back('{a: mem_addr, d: mem_dout});
      end
      mem_din = mem[mem_addr];
      if (mon_en) begin
        if (busy) busy_total++;
        if (done) done_total++;
        if (mem_wr && prev_wr) viol++;
        if (mem_wr && !cur_op) viol++;
        if (wdata_ready && (!cur_op || !busy)) viol++;
        if (rdata_valid && (cur_op || !busy)) viol++;
        if (prev_done && busy) viol++;
        if (done && !busy) viol++;
        prev_wr = mem_wr;
        prev_done = done;
      end
    end
  end

  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] wq [$];
  int            bursts = 0;
  int            stalls = 0;

  function automatic int mem_diff();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== shadow[k]) n++;
    return n;
  endfunction

  task automatic pulse_start(input logic o, input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1; op = o; base = b; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 4000) begin @(negedge clk); n++; end
    check_eq({tag, " done"}, 32'(done), 1);
    @(negedge clk);
    check_eq({tag, " busy drop"}, 32'(busy), 0);
    bursts++;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    wdata = d;
    wdata_valid = 1'b1;
    while (!wdata_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) stalls++;
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  // gap < 0 selects a random 0..3 idle gap before each word
  task automatic do_write(input logic [AW-1:0] b, input logic [AW-1:0] l, input int gap,
                          input bit inject, input int exp_busy);
    int w0 = wr_log.size();
    int b0 = busy_total;
    int bad = 0;
    cur_op = 1'b1;
    pulse_start(1'b1, b, l);
    for (int k = 0; k <= int'(l); k++) begin
      if (inject && k == 1) begin
        start = 1'b1; op = 1'b0; base = 9'd100; len = 9'd5;
        @(negedge clk);
        start = 1'b0;
      end
      send_word(wq[k], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    end
    wait_done("wr");
    check_eq("wr count", 32'(wr_log.size() - w0), 32'(l) + 1);
    for (int k = 0; k <= int'(l); k++) begin
      logic [AW-1:0] a;
      a = b + AW'(k);
      shadow[a] = wq[k];
      if (w0 + k < wr_log.size())
        if (wr_log[w0 + k].a !== a || wr_log[w0 + k].d !== wq[k]) bad++;
    end
    check_eq("wr addr/data order", 32'(bad), 0);
    check_eq("wr mem contents", 32'(mem_diff()), 0);
    if (exp_busy > 0) check_eq("wr busy cycles", 32'(busy_total - b0), 32'(exp_busy));
  endtask

  // mode 0: ready tied high; 1: random ready; 2: ready low 5 cycles on word 0
  task automatic do_read(input logic [AW-1:0] b, input logic [AW-1:0] l, input int mode,
                         input int exp_busy);
    logic [DW-1:0] got [$];
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    int  b0 = busy_total;
    int  w0 = wr_log.size();
    int  n = 0, held = 0, unstable = 0, bad = 0;
    bit  hold_prev = 1'b0, rr;
    cur_op = 1'b0;
    pulse_start(1'b0, b, l);
    while (!done && n < 20000) begin
      if (mode == 0) rr = 1'b1;
      else if (mode == 2) rr = !(rdata_valid && got.size() == 0 && held < 5);
      else rr = 1'($urandom_range(0, 1));
      if (mode == 2 && !rr) held++;
      if (hold_prev && !(rdata_valid && rdata == pd && mem_addr == pa)) unstable++;
      rdata_ready = rr;
      if (rdata_valid && rr) got.push_back(rdata);
      hold_prev = rdata_valid && !rr;
      pd = rdata;
      pa = mem_addr;
      @(negedge clk);
      n++;
    end
    wait_done("rd");
    rdata_ready = 1'b0;
    check_eq("rd count", 32'(got.size()), 32'(l) + 1);
    for (int k = 0; k < got.size(); k++)
      if (got[k] !== shadow[AW'(int'(b) + k)]) bad++;
    check_eq("rd data", 32'(bad), 0);
    check_eq("rd stable under backpressure", 32'(unstable), 0);
    check_eq("rd no writes", 32'(wr_log.size() - w0), 0);
    if (mode == 2) check_eq("rd held cycles", 32'(held), 5);
    if (exp_busy > 0) check_eq("rd busy cycles", 32'(busy_total - b0), 32'(exp_busy));
  endtask

  initial begin
    int w0, d0;
    for (int k = 0; k < DEPTH; k++) shadow[k] = init_val(k);
    repeat (3) @(negedge clk);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst done", 32'(done), 0);
    check_eq("rst wdata_ready", 32'(wdata_ready), 0);
    check_eq("rst rdata_valid", 32'(rdata_valid), 0);
    check_eq("rst rdata", 32'(rdata), 0);
    check_eq("rst mem_addr", 32'(mem_addr), 0);
    check_eq("rst mem_wr", 32'(mem_wr), 0);
    check_eq("rst mem_dout", 32'(mem_dout), 0);
    rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    wq = '{12'o1111, 12'o2222, 12'o3333};
    do_write(9'd2, 9'd2, 0, 1'b0, 7);
    do_read(9'd2, 9'd2, 0, 10);

    wq = '{12'd1, 12'd2, 12'd3, 12'd4};
    do_write(9'd510, 9'd3, 0, 1'b0, 9);
    do_read(9'd510, 9'd3, 0, 13);

    do_read(9'd2, 9'd2, 2, 15);

    wq = '{12'o7070, 12'o0707, 12'o1234, 12'o4321};
    do_write(9'd40, 9'd3, 4, 1'b1, 0);
    repeat (3) @(negedge clk);
    check_eq("ignored start stays idle", 32'(busy), 0);

    // Abort a 4-word write after its second word
    cur_op = 1'b1;
    w0 = wr_log.size();
    d0 = done_total;
    pulse_start(1'b1, 9'd300, 9'd3);
    send_word(12'o5555, 0);
    send_word(12'o6666, 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_eq("abort busy", 32'(busy), 0);
    check_eq("abort mem_wr", 32'(mem_wr), 0);
    check_eq("abort wdata_ready", 32'(wdata_ready), 0);
    repeat (4) @(negedge clk);
    check_eq("abort no done", 32'(done_total - d0), 0);
    check_eq("abort write count", 32'(wr_log.size() - w0), 2);
    shadow[300] = 12'o5555;
    shadow[301] = 12'o6666;
    check_eq("abort mem contents", 32'(mem_diff()), 0);

    for (int it = 0; it < 8; it++) begin
      logic [AW-1:0] b, l;
      b = AW'($urandom);
      l = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int k = 0; k <= int'(l); k++) wq.push_back(DW'($urandom));
        do_write(b, l, -1, 1'b0, 0);
      end
      do_read(b, l, 1, 0);
    end

    wq.delete();
    for (int k = 0; k < DEPTH; k++) wq.push_back(DW'($urandom));
    do_write(9'd77, 9'd511, 0, 1'b0, 1025);
    do_read(9'd77, 9'd511, 0, 1537);
    do_read(9'd0, 9'd0, 0, 4);

    check_eq("write stalls", 32'(stalls), 0);
    check_eq("protocol violations", 32'(viol), 0);
    check_eq("done pulses", 32'(done_total), 32'(bursts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
